// File: rtl/merge_words_pkg.sv
// Shared constants, output-register state encoding and width helper for the
// merge_words byte-to-word assembler.
package merge_pkg;

  localparam int unsigned BYTE_W_DEF = 8;
  localparam int unsigned NBYTES_DEF = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/merge_words_if.sv
// Byte-in / word-out stream bundle for merge_words; the assembler uses the
// slave view, the byte source and word sink together use the master view.
interface merge_words_if
  import merge_pkg::*;
#(
  parameter int unsigned BYTE_W = BYTE_W_DEF,
  parameter int unsigned NBYTES = NBYTES_DEF
);

  logic [BYTE_W-1:0]        byte_i;
  logic                     byte_valid_i;
  logic                     resync_i;
  logic [NBYTES*BYTE_W-1:0] word_o;
  logic                     word_valid_o;
  logic                     word_ready_i;

  modport master (
    output byte_i, byte_valid_i, resync_i, word_ready_i,
    input  word_o, word_valid_o
  );

  modport slave (
    input  byte_i, byte_valid_i, resync_i, word_ready_i,
    output word_o, word_valid_o
  );

endinterface

// File: rtl/merge_gap_timer.sv
// Inter-byte gap counter for merge_words, only built with MERGE_TIMEOUT_EN.
// done is high during the cycle in which the gap reaches TIMEOUT_CYC.
module merge_gap_timer
  import merge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic done
);

  localparam int unsigned GAP_W = cnt_width(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(TIMEOUT_CYC - 1);

  logic [GAP_W-1:0] gap_q, gap_d;

  always_comb begin
    gap_d = gap_q;
    if (clr || !run) begin
      gap_d = '0;
    end else if (gap_q != LAST_GAP) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  assign done = run && !clr && (gap_q == LAST_GAP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/merge_words.sv
// Packs the UART byte stream into NBYTES-wide words behind a one-entry holding
// register. Define MERGE_TIMEOUT_EN to abort partial words after an idle gap.
module merge_words
  import merge_pkg::*;
#(
  parameter int unsigned BYTE_W      = BYTE_W_DEF,
  parameter int unsigned NBYTES      = NBYTES_DEF,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned DROP_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  merge_words_if.slave                  bus,
  output logic [cnt_width(NBYTES)-1:0]  byte_cnt_o,
  output logic                          overflow_o,
  output logic [DROP_W-1:0]             drop_cnt_o,
  output logic                          timeout_o
);

  localparam int unsigned WORD_W = NBYTES * BYTE_W;
  localparam int unsigned CNT_W  = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  if (NBYTES < 2 || NBYTES > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("merge_words: NBYTES must be 2..8 and TIMEOUT_CYC at least 2");
  end

  out_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [WORD_W-1:0] base_asm, merged;
  logic [CNT_W-1:0]  base_cnt;
  logic              pop, complete, timeout_d;

  // Bytes are treated as raw bits; signed samples pass through untouched.
  always_comb begin
    base_asm = bus.resync_i ? '0 : asm_q;
    base_cnt = bus.resync_i ? '0 : cnt_q;
    if (MSB_FIRST) begin
      merged = (base_asm << BYTE_W) | WORD_W'(bus.byte_i);
    end else begin
      merged = (base_asm >> BYTE_W) | (WORD_W'(bus.byte_i) << (WORD_W - BYTE_W));
    end
    complete = bus.byte_valid_i && (base_cnt == LAST_CNT);
    pop      = (state_q == ST_FULL) && bus.word_ready_i;
  end

`ifdef MERGE_TIMEOUT_EN
  logic gap_done;
  logic timeout_q;

  merge_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.byte_valid_i | bus.resync_i),
    .run  (cnt_q != '0),
    .done (gap_done)
  );

  // An arriving byte or resync in the expiry cycle takes priority over the abort.
  assign timeout_d = gap_done && !bus.byte_valid_i && !bus.resync_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_d = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (bus.byte_valid_i) begin
      if (complete) begin
        asm_d = '0;
        cnt_d = '0;
      end else begin
        asm_d = merged;
        cnt_d = base_cnt + CNT_W'(1);
      end
    end else if (bus.resync_i || timeout_d) begin
      asm_d = '0;
      cnt_d = '0;
    end

    // A completion while the held word is not being consumed loses the new word.
    case (state_q)
      ST_EMPTY: begin
        if (complete) begin
          state_d = ST_FULL;
          word_d  = merged;
        end
      end
      ST_FULL: begin
        if (complete && pop) begin
          word_d = merged;
        end else if (complete) begin
          overflow_d = 1'b1;
          if (drop_q != '1) begin
            drop_d = drop_q + DROP_W'(1);
          end
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      word_q     <= '0;
      asm_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.word_o       = word_q;
  assign bus.word_valid_o = (state_q == ST_FULL);
  assign byte_cnt_o       = cnt_q;
  assign overflow_o       = overflow_q;
  assign drop_cnt_o       = drop_q;

endmodule

// File: tb/tb_merge_words.sv
// Bench for merge_words: MSB-first and LSB-first instances share one directed
// byte stream and are checked every cycle against a queue-based reference.
module tb_merge_words;

  localparam int unsigned BW = 8;
  localparam int unsigned NB = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  merge_words_if #(.BYTE_W(BW), .NBYTES(NB)) bus_m ();
  merge_words_if #(.BYTE_W(BW), .NBYTES(NB)) bus_l ();

  logic [1:0]    cnt_m, cnt_l;
  logic          ovf_m, ovf_l;
  logic [DW-1:0] drop_m, drop_l;
  logic          to_m, to_l;

  merge_words #(.BYTE_W(BW), .NBYTES(NB), .MSB_FIRST(1'b1), .TIMEOUT_CYC(TO), .DROP_W(DW)) dut_m (
    .clk(clk), .rst(rst), .bus(bus_m.slave),
    .byte_cnt_o(cnt_m), .overflow_o(ovf_m), .drop_cnt_o(drop_m), .timeout_o(to_m)
  );

  merge_words #(.BYTE_W(BW), .NBYTES(NB), .MSB_FIRST(1'b0), .TIMEOUT_CYC(TO), .DROP_W(DW)) dut_l (
    .clk(clk), .rst(rst), .bus(bus_l.slave),
    .byte_cnt_o(cnt_l), .overflow_o(ovf_l), .drop_cnt_o(drop_l), .timeout_o(to_l)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Reference model state
  logic [7:0]  m_part[$];
  bit          m_full;
  logic [31:0] m_word_m, m_word_l;
  bit          m_ovf, m_to;
  int          m_drops, m_gap;

  function automatic logic [31:0] packWord(input logic [7:0] q[$], input bit msb);
    logic [31:0] w = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (msb) w = (w << 8) | 32'(q[i]);
      else     w = w | (32'(q[i]) << (8 * i));
    end
    return w;
  endfunction

  always @(posedge clk) begin : model_step
    logic [31:0] nw_m, nw_l;
    bit complete, pop;
    if (rst === 1'b0) begin
      m_part.delete();
      m_full = 0; m_word_m = '0; m_word_l = '0;
      m_ovf = 0; m_to = 0; m_drops = 0; m_gap = 0;
    end else begin
      pop      = m_full && bus_m.word_ready_i;
      complete = 0;
      m_to     = 0;
      nw_m     = '0;
      nw_l     = '0;
      if (bus_m.resync_i) begin
        m_part.delete();
        m_gap = 0;
      end
      if (bus_m.byte_valid_i) begin
        m_part.push_back(bus_m.byte_i);
        m_gap = 0;
        if (m_part.size() == NB) begin
          complete = 1;
          nw_m = packWord(m_part, 1'b1);
          nw_l = packWord(m_part, 1'b0);
          m_part.delete();
        end
      end else if (!bus_m.resync_i && m_part.size() != 0) begin
`ifdef MERGE_TIMEOUT_EN
        if (m_gap == TO - 1) begin
          m_part.delete();
          m_gap = 0;
          m_to  = 1;
        end else begin
          m_gap++;
        end
`endif
      end
      if (complete) begin
        if (!m_full || pop) begin
          m_full = 1; m_word_m = nw_m; m_word_l = nw_l;
        end else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end else if (pop) begin
        m_full = 0;
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("valid_m", bus_m.word_valid_o, m_full);
    cmp("valid_l", bus_l.word_valid_o, m_full);
    if (m_full) begin
      cmp("word_m", bus_m.word_o, m_word_m);
      cmp("word_l", bus_l.word_o, m_word_l);
    end
    cmp("cnt_m", cnt_m, m_part.size());
    cmp("cnt_l", cnt_l, m_part.size());
    cmp("ovf_m", ovf_m, m_ovf);
    cmp("ovf_l", ovf_l, m_ovf);
    cmp("drop_m", drop_m, m_drops);
    cmp("drop_l", drop_l, m_drops);
    cmp("timeout_m", to_m, m_to);
    cmp("timeout_l", to_l, m_to);
  endtask

  always @(negedge clk) if (chk_en) checkOutput();

  task automatic applyStimulus(input bit v, input logic [7:0] b, input bit rs, input bit rdy);
    bus_m.byte_valid_i = v;  bus_l.byte_valid_i = v;
    bus_m.byte_i       = b;  bus_l.byte_i       = b;
    bus_m.resync_i     = rs; bus_l.resync_i     = rs;
    bus_m.word_ready_i = rdy; bus_l.word_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBytes(input logic [31:0] w, input bit rdy);
    for (int i = 3; i >= 0; i--) applyStimulus(1'b1, w[8*i +: 8], 1'b0, rdy);
  endtask

  initial begin
    rst = 1'b0;
    bus_m.byte_valid_i = 0; bus_l.byte_valid_i = 0;
    bus_m.byte_i = '0;      bus_l.byte_i = '0;
    bus_m.resync_i = 0;     bus_l.resync_i = 0;
    bus_m.word_ready_i = 0; bus_l.word_ready_i = 0;
    applyStimulus(0, 8'h00, 0, 0);
    chk_en = 1'b1;
    applyStimulus(0, 8'h00, 0, 0);
    rst = 1'b1;
    cmp("rst_word_m", bus_m.word_o, 32'h0);
    cmp("rst_word_l", bus_l.word_o, 32'h0);
    cmp("rst_valid", bus_m.word_valid_o, 1'b0);
    cmp("rst_cnt", cnt_m, 2'd0);
    applyStimulus(0, 8'h00, 0, 1);

    // Basic word, both byte orders
    sendBytes(32'h12345678, 1'b1);
    cmp("lit_word_m", bus_m.word_o, 32'h12345678);
    cmp("lit_word_l", bus_l.word_o, 32'h78563412);
    cmp("lit_model_m", m_word_m, 32'h12345678);
    cmp("lit_valid", bus_m.word_valid_o, 1'b1);
    applyStimulus(0, 8'h00, 0, 1);
    cmp("lit_valid_fall", bus_m.word_valid_o, 1'b0);

    // Overflow with ready low
    sendBytes(32'h01020304, 1'b0);
    sendBytes(32'h05060708, 1'b0);
    cmp("ovf_word_m", bus_m.word_o, 32'h01020304);
    cmp("ovf_flag", ovf_m, 1'b1);
    cmp("ovf_drop", drop_m, 8'd1);
    applyStimulus(0, 8'h00, 0, 1);
    cmp("ovf_pop", bus_m.word_valid_o, 1'b0);

    // Pop coincident with completion
    sendBytes(32'hA1A2A3A4, 1'b0);
    applyStimulus(1, 8'hB1, 0, 0);
    applyStimulus(1, 8'hB2, 0, 0);
    applyStimulus(1, 8'hB3, 0, 0);
    applyStimulus(1, 8'hB4, 0, 1);
    cmp("swap_word_m", bus_m.word_o, 32'hB1B2B3B4);
    cmp("swap_drop", drop_m, 8'd1);
    applyStimulus(0, 8'h00, 0, 1);

    // Resync with and without a byte
    applyStimulus(1, 8'hAA, 0, 1);
    applyStimulus(1, 8'hBB, 0, 1);
    applyStimulus(1, 8'h11, 1, 1);
    cmp("resync_cnt", cnt_m, 2'd1);
    applyStimulus(1, 8'h22, 0, 1);
    applyStimulus(1, 8'h33, 0, 1);
    applyStimulus(1, 8'h44, 0, 1);
    cmp("resync_word_m", bus_m.word_o, 32'h11223344);
    cmp("resync_word_l", bus_l.word_o, 32'h44332211);
    applyStimulus(0, 8'h00, 0, 1);
    applyStimulus(1, 8'h55, 0, 1);
    applyStimulus(0, 8'h00, 1, 1);
    cmp("resync_alone_cnt", cnt_m, 2'd0);

    // Idle gap after a partial word
    applyStimulus(1, 8'hC1, 0, 1);
    applyStimulus(1, 8'hC2, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 8'h00, 0, 1);
`ifdef MERGE_TIMEOUT_EN
      cmp("gap_timeout", to_m, (i == 16));
`else
      cmp("gap_timeout", to_m, 1'b0);
`endif
    end
    applyStimulus(0, 8'h00, 1, 1);
    sendBytes(32'hDEADBEEF, 1'b1);
    cmp("gap_word_m", bus_m.word_o, 32'hDEADBEEF);
    applyStimulus(0, 8'h00, 0, 1);
    applyStimulus(1, 8'h01, 0, 1);
    for (int i = 0; i < 15; i++) applyStimulus(0, 8'h00, 0, 1);
    applyStimulus(1, 8'h02, 0, 1);
    cmp("expiry_byte_cnt", cnt_m, 2'd2);
    cmp("expiry_byte_to", to_m, 1'b0);
    applyStimulus(0, 8'h00, 1, 1);

    // Reset with a held word and a partial word in flight
    sendBytes(32'h61626364, 1'b0);
    applyStimulus(1, 8'h71, 0, 0);
    applyStimulus(1, 8'h72, 0, 0);
    applyStimulus(1, 8'h73, 0, 0);
    rst = 1'b0;
    applyStimulus(0, 8'h00, 0, 0);
    rst = 1'b1;
    cmp("mid_rst_word", bus_m.word_o, 32'h0);
    cmp("mid_rst_valid", bus_m.word_valid_o, 1'b0);
    cmp("mid_rst_cnt", cnt_m, 2'd0);
    cmp("mid_rst_ovf", ovf_m, 1'b0);
    cmp("mid_rst_drop", drop_m, 8'd0);
    sendBytes(32'h81828384, 1'b1);
    cmp("post_rst_word_m", bus_m.word_o, 32'h81828384);
    cmp("post_rst_word_l", bus_l.word_o, 32'h84838281);
    applyStimulus(0, 8'h00, 0, 1);

    // Drop counter saturation
    for (int w = 0; w < 261; w++) begin
      for (int k = 0; k < 4; k++) applyStimulus(1, 8'(w * 4 + k), 0, 0);
    end
    cmp("sat_drop", drop_m, 8'd255);
    cmp("sat_ovf", ovf_m, 1'b1);
    cmp("sat_word_m", bus_m.word_o, 32'h00010203);
    applyStimulus(0, 8'h00, 0, 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/merge_words.md
Name: merge_words

Overview:
- Parametrised byte-to-word assembler that packs the UART receiver byte stream into NBYTES-wide sample words for the FM demodulator datapath.
- Unlike the fixed 4-byte merger, it provides:
  - a byte counter with explicit framing;
  - selectable byte order;
  - a valid/ready output handshake with a holding register;
  - overflow and drop accounting;
  - a resync input.
- Sits between the UART RX block and the sample FIFO/demodulator input.

Parameters:
- BYTE_W, 8, width of one input byte.
- NBYTES, 4, bytes per output word; legal range 2..8.
- MSB_FIRST, 1, 1 = first received byte lands in the word MSB; 0 = first byte lands in the LSB.
- TIMEOUT_CYC, 1024, inter-byte gap (in clk cycles) that aborts a partial word; used only with MERGE_TIMEOUT_EN.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-low reset.
- byte_i, input, BYTE_W, received byte, signed two's-complement data.
- byte_valid_i, input, 1, byte_i valid this cycle; always accepted (no backpressure to UART).
- resync_i, input, 1, discard any partial word and restart framing.
- word_o, output, NBYTES*BYTE_W, assembled signed word.
- word_valid_o, output, 1, word_o holds an unconsumed word.
- word_ready_i, input, 1, downstream consumes word_o when word_valid_o & word_ready_i.
- byte_cnt_o, output, clog2(NBYTES), bytes collected in the current partial word.
- overflow_o, output, 1, sticky: a completed word was dropped.
- drop_cnt_o, output, DROP_W, number of dropped words, saturating.
- timeout_o, output, 1, one-cycle pulse when a partial word is aborted by timeout.

Behaviour:
- Reset (rst=0 at a clock edge) forces:
  - word_o=0, word_valid_o=0, overflow_o=0, drop_cnt_o=0, timeout_o=0, byte_cnt_o=0;
  - assembly register cleared.
- Reset mid-word discards the partial word and any held output word.
- Assembly:
  - Each accepted byte goes into the assembly register.
  - MSB_FIRST=1: shift left by BYTE_W, new byte inserted at the LSB.
  - MSB_FIRST=0: shift right by BYTE_W, new byte inserted at the MSB.
  - byte_cnt increments per byte, range 0..NBYTES-1.
- Completion: byte_valid_i with byte_cnt==NBYTES-1.
  - The completed word is the assembly register merged with byte_i; byte_cnt wraps to 0.
  - Latency: word_valid_o rises the cycle after the last byte is accepted.
- Output holding register, two states:
  - EMPTY: word_valid_o=0.
  - FULL: word_valid_o=1; word_o stays stable until consumed.
- Transitions:
  - EMPTY + completion -> FULL.
  - FULL + pop, no completion -> EMPTY.
  - FULL + pop + completion in the same cycle -> stays FULL with the new word; no overflow.
  - FULL + completion, no pop -> new word dropped, held word kept, overflow_o set, drop_cnt_o += 1 (saturates at all-ones).
- resync_i:
  - Clears byte_cnt and the assembly register.
  - Simultaneous with byte_valid_i: that byte becomes byte 0 of the new word (byte_cnt=1 next cycle).
  - Never affects the output register, overflow_o or drop_cnt_o.
- overflow_o is cleared only by reset.
- Arithmetic: no sign extension or modification; the word is pure concatenation.

Optional Feature:
- MERGE_TIMEOUT_EN defined:
  - A gap counter runs while byte_cnt!=0 and resets on every accepted byte.
  - When it reaches TIMEOUT_CYC with no byte that cycle:
    - partial word discarded, byte_cnt=0;
    - timeout_o pulses for one cycle.
  - A byte arriving in the expiry cycle wins: accepted normally, no timeout.
  - resync_i also clears the gap counter.
- MERGE_TIMEOUT_EN undefined:
  - No gap counter is synthesised, timeout_o is tied to 0, and TIMEOUT_CYC is ignored.

Decomposition:
- Package merge_pkg holds:
  - default BYTE_W/NBYTES constants;
  - a clog2-based count-width function;
  - the output-state encoding (ST_EMPTY, ST_FULL).
- One natural sub-module: merge_gap_timer. It is instantiated only under MERGE_TIMEOUT_EN and has inputs clk, rst, clr, run and a done pulse.

Test Plan:
- NBYTES=4, MSB_FIRST=1, word_ready_i=1: bytes 0x12,0x34,0x56,0x78 on consecutive cycles -> word_o=0x12345678; word_valid_o high for one cycle, one cycle after 0x78.
- MSB_FIRST=0, same bytes -> word_o=0x78563412.
- word_ready_i=0, 8 bytes 0x01..0x08 -> word_o=0x01020304 held, overflow_o=1, drop_cnt_o=1. Raising ready then pops 0x01020304 and word_valid_o falls.
- Held word plus word_ready_i=1 in the exact cycle the second word completes -> no overflow; word_o becomes the second word next cycle.
- Bytes 0xAA,0xBB, then resync_i with byte 0x11, then 0x22,0x33,0x44 -> word_o=0x11223344, no stale bytes.
- MERGE_TIMEOUT_EN, TIMEOUT_CYC=16: two bytes, then 20 idle cycles -> timeout_o pulses 16 cycles after the second byte. The next four bytes 0xDE,0xAD,0xBE,0xEF -> 0xDEADBEEF.
- rst low after 3 bytes -> all outputs 0. The next 4 bytes form a clean word.
